// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-pass shift issue unit.
// Type codes match the barrel shifter's t input.
package shift_pkg;

    localparam logic [1:0] SHT_SRL = 2'b00;
    localparam logic [1:0] SHT_SRA = 2'b01;
    localparam logic [1:0] SHT_SLL = 2'b10;

    localparam logic [2:0] MAX_PASS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/shift_issue_unit_barrelshifter8.sv
// 8-bit combinational barrel shifter, 0..7 per pass.
// t: 1X left, 00 logical right, 01 arithmetic right.
module barrelshifter8
    import shift_pkg::*;
(
    input  logic [7:0] d,
    input  logic [2:0] s,
    input  logic [1:0] t,
    output logic [7:0] q
);

    // select shift direction/kind; t=11 falls into the left case
    always_comb begin
        q = d;
        unique case (1'b1)
            t[1]:          q = d << s;
            !t[1] && t[0]: q = $signed(d) >>> s;
            default:       q = d >> s;
        endcase
    end

endmodule

// File: rtl/shift_issue_unit.sv
// Multi-pass front end for barrelshifter8: shifts of 0..15
// in up to three passes, result held until consumed.
module shift_issue_unit
    import shift_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_carry,
    output logic             out_zero
);

    generate
        if (AMT_W != 4) begin : g_bad_amt_w
            $error("shift_issue_unit: only AMT_W=4 is supported");
        end
    endgenerate

    state_e           state;
    state_e           state_nxt;
    logic [7:0]       work;
    logic [AMT_W-1:0] rem;
    logic [1:0]       typ;
    logic             carry;
    logic [2:0]       pass;
    logic [7:0]       shq;
    logic             last;
    logic             accept;

    // carry is the last bit to leave the original operand
    function automatic logic carry_calc(
        input logic [7:0]       d,
        input logic [AMT_W-1:0] n,
        input logic [1:0]       t
    );
        logic c;
        c = 1'b0;
        if (n == '0)
            c = 1'b0;
        else if (n > AMT_W'(8))
            c = (t == SHT_SRA) ? d[7] : 1'b0;
        else if (t[1])
            c = d[3'(AMT_W'(8) - n)];
        else
            c = d[3'(n - AMT_W'(1))];
        return c;
    endfunction

    // pass size and handshake decode
    always_comb begin
        pass     = (rem > AMT_W'(MAX_PASS)) ? MAX_PASS : rem[2:0];
        last     = (rem <= AMT_W'(MAX_PASS));
        in_ready = (state == ST_IDLE) ||
                   ((state == ST_DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    barrelshifter8 u_bs (
        .d (work),
        .s (pass),
        .t (typ),
        .q (shq)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (in_valid)
                    state_nxt = ST_SHIFT;
            ST_SHIFT:
                if (last)
                    state_nxt = ST_DONE;
            ST_DONE:
                if (out_ready)
                    state_nxt = in_valid ? ST_SHIFT : ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // work registers and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            rem       <= '0;
            typ       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            if ((state == ST_DONE) && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                work  <= in_data;
                rem   <= in_amt;
                typ   <= in_type;
                carry <= carry_calc(in_data, in_amt, in_type);
            end else if (state == ST_SHIFT) begin
                work <= shq;
                rem  <= rem - AMT_W'(pass);
                if (last) begin
                    out_valid <= 1'b1;
                    out_data  <= shq;
                    out_carry <= carry;
                    out_zero  <= (shq == 8'h00);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_unit.sv
// Scoreboard bench for shift_issue_unit.
// Expected results come from a wide-word shift model.
module tb_shift_issue_unit;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic [1:0] in_type;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_zero;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic       zero;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   pres = 0;

    shift_issue_unit #(.AMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_type   (in_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d,
                                   input logic [3:0] n,
                                   input logic [1:0] t);
        logic [23:0] v;
        exp_t        e;
        if (t[1]) begin
            v = {16'h0, d} << n;
            e.data  = v[7:0];
            e.carry = (n != 0) && v[8];
        end else if (t[0]) begin
            v = $signed({d, 16'h0}) >>> n;
            e.data  = v[23:16];
            e.carry = (n != 0) && v[15];
        end else begin
            v = {d, 16'h0} >> n;
            e.data  = v[23:16];
            e.carry = (n != 0) && v[15];
        end
        e.zero = (e.data == 8'h00);
        e.lat  = (n == 15) ? 3 : (n >= 8) ? 2 : 1;
        e.acc  = 0;
        return e;
    endfunction

    // call just after a rising edge
    task automatic issue(input logic [7:0] d, input logic [3:0] n,
                         input logic [1:0] t, output int waits);
        exp_t e;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = n;
        in_type  = t;
        @(negedge clk);
        while (!in_ready && waits < 60) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 60) begin
            chk("accept_timeout", 32'(waits), 32'd0);
        end else begin
            e     = model(d, n, t);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                if (!pres) begin
                    chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    pres = 1;
                end
                if (out_ready) begin
                    chk("data", 32'(out_data), 32'(sb[0].data));
                    chk("carry", 32'(out_carry), 32'(sb[0].carry));
                    chk("zero", 32'(out_zero), 32'(sb[0].zero));
                    void'(sb.pop_front());
                    pres = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_type   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        issue(8'hB4, 4'd3, SHT_SRL, w);
        drain();
        chk("srl_b4_3", 32'(out_data), 32'h16);
        issue(8'h90, 4'd10, SHT_SRA, w);
        drain();
        chk("sra_90_10", 32'(out_data), 32'hFF);
        issue(8'h81, 4'd8, SHT_SLL, w);
        drain();
        chk("sll_81_8_z", 32'(out_zero), 32'd1);
        issue(8'hFF, 4'd15, SHT_SLL, w);
        drain();
        chk("sll_ff_15_c", 32'(out_carry), 32'd0);
        for (int t = 0; t < 4; t++) begin
            issue(8'h5A, 4'd0, 2'(t), w);
            drain();
            chk("n0_data", 32'(out_data), 32'h5A);
        end

        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom), 4'($urandom), 2'($urandom), w);
        end
        drain();
        for (int n = 0; n < 16; n++) begin
            issue(8'hA5, 4'(n), SHT_SRA, w);
            issue(8'h3C, 4'(n), SHT_SLL, w);
        end
        drain();

        // backpressure
        out_ready = 1'b0;
        issue(8'hB4, 4'd3, SHT_SRL, w);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", 32'(out_data), 32'h16);
            chk("bp_carry", 32'(out_carry), 32'd1);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(8'h90, 4'd10, SHT_SRA, w);
        chk("same_edge", 32'(w), 32'd0);
        drain();

        // reset during a 3-pass shift
        issue(8'h7F, 4'd15, SHT_SRL, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        pres = 0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(8'h81, 4'd8, SHT_SLL, w);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
